// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//   Direct-mapped instruction cache that sits between the fetch stage and the
//   instruction memory model. A lookup that hits returns the instruction in the
//   same cycle as pc. A miss refills the whole line from main memory, one word
//   per req/ack handshake, and fetch sees hit=0 until the refill is done.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pc           16-bit byte address from fetch (bit 0 ignored)
//   flush        invalidate every line
//   hit          instruction is valid for the current pc this cycle
//   instruction  cached word, 16'h0000 (NOP) when hit=0
//   mem_req      refill word request, held until mem_ack
//   mem_addr     byte address of the requested word, stable while mem_req=1
//   mem_ack      mem_rdata valid, completes one word transfer
//   mem_rdata    refill data
// -----------------------------------------------------------------------------
module icache_responder #(
    parameter int LINES     = 16,
    parameter int BLOCK_WDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        flush,
    output logic        hit,
    output logic [15:0] instruction,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(BLOCK_WDS);
    localparam int TAG_W = 16 - 1 - OFF_W - IDX_W;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, state_nxt;

    // Address split: [TAG | INDEX | WORD OFFSET | BYTE]
    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_idx;
    logic [OFF_W-1:0] pc_off;
    logic             pc_byte_unused;

    assign pc_tag         = pc[15 -: TAG_W];
    assign pc_idx         = pc[OFF_W+1 +: IDX_W];
    assign pc_off         = pc[1 +: OFF_W];
    assign pc_byte_unused = pc[0];

    // Cache storage
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [15:0]      data_arr [LINES*BLOCK_WDS];

    // Refill bookkeeping for the address that missed
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [OFF_W-1:0] word_cnt;
    logic             flush_seen;

    logic lookup_hit;
    logic word_ack;
    logic last_ack;

    // -------------------------------------------------------------------------
    // Lookup, handshake decode and next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        lookup_hit  = 1'b0;
        word_ack    = 1'b0;
        last_ack    = 1'b0;
        instruction = '0;

        // A flush in the same cycle masks the lookup so stale lines never hit.
        if (state == IDLE) begin
            lookup_hit = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag) && !flush;
        end

        if (lookup_hit) begin
            instruction = data_arr[{pc_idx, pc_off}];
        end

        // Acks are only meaningful while a word is being requested.
        word_ack = (state == REFILL) && mem_ack;
        last_ack = word_ack && (word_cnt == OFF_W'(BLOCK_WDS - 1));

        case (state)
            IDLE:    if (!lookup_hit) state_nxt = REFILL;
            REFILL:  if (last_ack)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hit      = lookup_hit;
    assign mem_req  = (state == REFILL);
    assign mem_addr = mem_req ? {miss_tag, miss_idx, word_cnt, 1'b0} : 16'h0000;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples values from before the edge.
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            miss_tag   <= '0;
            miss_idx   <= '0;
            word_cnt   <= '0;
            flush_seen <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && !lookup_hit) begin
                miss_tag   <= pc_tag;
                miss_idx   <= pc_idx;
                word_cnt   <= '0;
                flush_seen <= 1'b0;
            end

            if (state == REFILL) begin
                if (flush) begin
                    flush_seen <= 1'b1;
                end
                if (last_ack) begin
                    word_cnt   <= '0;
                    flush_seen <= 1'b0;
                end else if (word_ack) begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end

            // A flush seen at any point of the refill, including the final
            // ack cycle, keeps the refilled line invalid.
            if (last_ack && !flush_seen && !flush) begin
                valid[miss_idx] <= 1'b1;
            end
            if (flush) begin
                valid <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag and data arrays
    // -------------------------------------------------------------------------
    // NOTE: the arrays carry no reset; the valid bits alone decide whether a
    // line's contents can be used, so resetting the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (word_ack) begin
            data_arr[{miss_idx, word_cnt}] <= mem_rdata;
        end
        if (last_ack) begin
            tag_arr[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
//   Self-checking bench for icache_responder. A memory responder returns a
//   fixed function of the requested address, so any hit must return
//   mem_word(pc). The reference tracks only which line blocks are resident and
//   the one outstanding refill transaction (base address + words delivered).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icache_responder;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [15:0] pc        = 16'h0000;
    logic        flush     = 1'b0;
    logic        mem_ack   = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        hit;
    logic [15:0] instruction;
    logic        mem_req;
    logic [15:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // 0: ack every cycle, 1: every 3rd cycle, 2: random, 3: never
    int ack_mode = 3;
    int ack_ctr  = 0;

    always #5 clk = ~clk;

    icache_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .flush       (flush),
        .hit         (hit),
        .instruction (instruction),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Main memory contents: a fixed function of the word address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], ~a[15:8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Memory responder
    // -------------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        ack_ctr++;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (ack_ctr % 3 == 0);
            2:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = 1'b0;
        endcase
        mem_rdata = mem_req ? mem_word(mem_addr) : 16'($urandom);
    end

    // -------------------------------------------------------------------------
    // Reference: resident blocks + one outstanding refill transaction
    // -------------------------------------------------------------------------
    bit          m_valid [16];
    logic [8:0]  m_tag   [16];
    bit          m_busy  = 1'b0;
    logic [15:0] m_base  = 16'h0000;
    int          m_cnt   = 0;
    bit          m_fseen = 1'b0;

    function automatic bit model_hit(input logic [15:0] a, input logic f);
        return !m_busy && !f && m_valid[a[6:3]] && (m_tag[a[6:3]] == a[15:7]);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        bit h;
        if (!rst_n) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy  = 1'b0;
            m_cnt   = 0;
            m_fseen = 1'b0;
        end else if (!m_busy) begin
            h = model_hit(pc, flush);
            if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
            if (!h) begin
                m_busy  = 1'b1;
                m_base  = {pc[15:3], 3'b000};
                m_cnt   = 0;
                m_fseen = 1'b0;
            end
        end else begin
            if (flush) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_fseen = 1'b1;
            end
            if (mem_ack) begin
                m_cnt++;
                if (m_cnt == 4) begin
                    m_busy = 1'b0;
                    if (!m_fseen) begin
                        m_valid[m_base[6:3]] = 1'b1;
                        m_tag[m_base[6:3]]   = m_base[15:7];
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Cycle-by-cycle compare against the reference
    // -------------------------------------------------------------------------
    always @(negedge clk) begin : cmp
        bit eh;
        if (rst_n) begin
            eh = model_hit(pc, flush);
            check("hit", hit, eh);
            check("instruction", instruction, eh ? mem_word({pc[15:1], 1'b0}) : 16'h0000);
            check("mem_req", mem_req, m_busy);
            if (m_busy) check("mem_addr", mem_addr, m_base + 16'(m_cnt * 2));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input int bound, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_req !== lvl && n < bound);
        check(name, mem_req, lvl);
    endtask

    logic [15:0] pool [8] = '{16'h0084, 16'h0880, 16'h0100, 16'h0200,
                              16'h0318, 16'h1040, 16'h0048, 16'h2878};
    logic [15:0] t2_addr [4] = '{16'h0080, 16'h0082, 16'h0084, 16'h0086};

    initial begin
        bit did_rst = 1'b0;

        // 1: reset, then a reset in the middle of a refill
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pc = 16'h0040;
        @(negedge clk);
        check("t1 miss after reset", hit, 1'b0);
        tick();
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t1 reset mem_req", mem_req, 1'b0);
        check("t1 reset hit", hit, 1'b0);
        tick();
        rst_n    = 1'b1;
        ack_mode = 0;
        @(negedge clk);
        check("t1 line invalid after reset", hit, 1'b0);
        wait_req(1'b0, 20, "t1 refill done");

        // 2: cold miss, ack every cycle
        tick();
        pc = 16'h0084;
        @(negedge clk);
        check("t2 cold miss", hit, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2 mem_req", mem_req, 1'b1);
            check("t2 mem_addr", mem_addr, t2_addr[i]);
        end
        @(negedge clk);
        check("t2 hit 6th cycle", hit, 1'b1);
        check("t2 instruction", instruction, 16'h84FF);

        // 3: same-line hits
        for (int i = 0; i < 4; i++) begin
            tick();
            pc = 16'h0080 + 16'(2 * i);
            @(negedge clk);
            check("t3 line hit", hit, 1'b1);
            check("t3 no mem_req", mem_req, 1'b0);
        end

        // 4: conflict miss with slow memory, then the evicted line misses
        tick();
        ack_mode = 1;
        pc = 16'h0880;
        wait_req(1'b1, 4, "t4 refill start");
        wait_req(1'b0, 60, "t4 refill done");
        check("t4 new line hits", hit, 1'b1);
        tick();
        pc = 16'h0084;
        @(negedge clk);
        check("t4 evicted line misses", hit, 1'b0);
        wait_req(1'b0, 60, "t4 re-refill done");

        // 5: pc changes during a refill
        tick();
        ack_mode = 0;
        pc = 16'h0100;
        tick();
        tick();
        pc = 16'h0200;
        wait_req(1'b0, 20, "t5 first refill done");
        check("t5 new pc misses", hit, 1'b0);
        @(negedge clk);
        check("t5 second refill req", mem_req, 1'b1);
        check("t5 second refill addr", mem_addr, 16'h0200);
        wait_req(1'b0, 20, "t5 second refill done");

        // 6: flush during the 3rd word of a refill
        tick();
        pc = 16'h0318;
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6 flushed refill no hit", hit, 1'b0);
        @(negedge clk);
        check("t6 refill reissued", mem_req, 1'b1);
        check("t6 refill reissued addr", mem_addr, 16'h0318);
        wait_req(1'b0, 20, "t6 refill done");
        check("t6 refetched line hits", hit, 1'b1);
        tick();
        pc = 16'h0200;
        @(negedge clk);
        check("t6 earlier line flushed", hit, 1'b0);

        // Random traffic with random acks and occasional flushes
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            pc    = pool[$urandom_range(0, 7)] + 16'(2 * $urandom_range(0, 3));
            flush = ($urandom_range(0, 15) == 0);
            if (i > 1500 && !did_rst && mem_req) begin
                did_rst = 1'b1;
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("rand reset mem_req", mem_req, 1'b0);
                check("rand reset hit", hit, 1'b0);
                tick();
                rst_n = 1'b1;
            end
        end
        flush = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
